bf_radix2_pipe: RTL

//   Pipelined, parametrised radix-2 DIF butterfly for the R2MDC FFT datapath: Y0 = A+B, Y1 = (A-B)*W.

---
 rtl/fft_pkg.sv | 45 ++++
 rtl/cmult_pipe.sv | 56 +++++
 rtl/bf_radix2_pipe.sv | 116 +++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath defaults and the round-half-up / saturate helper used by
// the butterfly and the R2MDC stage controller.
package fft_pkg;

  localparam int FFT_DW   = 16;
  localparam int FFT_FRAC = 8;
  // Working width of rnd_sat; must cover the widest caller (2*DW+3 bits).
  localparam int RS_W     = 64;

  typedef struct packed {
    logic signed [RS_W-1:0] val;
    logic                   ovf;
  } rs_t;

  // Adds half an LSB then shifts arithmetically, so ties round toward +inf.
  // With sat_en=0 the value is passed through and the caller keeps the low dw bits.
  function automatic rs_t rnd_sat(input logic signed [RS_W-1:0] value,
                                  input int                     shift,
                                  input int                     dw,
                                  input logic                   sat_en);
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    rs_t                    res;
    one = {{(RS_W-1){1'b0}}, 1'b1};
    if (shift > 0) r = (value + (one <<< (shift - 1))) >>> shift;
    else           r = value;
    hi = (one <<< (dw - 1)) - one;
    lo = -(one <<< (dw - 1));
    res.val = r;
    res.ovf = 1'b0;
    if (sat_en) begin
      if (r > hi) begin
        res.val = hi;
        res.ovf = 1'b1;
      end else if (r < lo) begin
        res.val = lo;
        res.ovf = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cmult_pipe.sv
// Two-stage complex multiplier: stage 1 registers x and W (optionally conjugated),
// stage 2 registers the four partial products at full precision.
module cmult_pipe
  import fft_pkg::*;
#(
  parameter int DW = FFT_DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic signed [DW:0]    x_re,
  input  logic signed [DW:0]    x_im,
  input  logic signed [DW-1:0]  w_re,
  input  logic signed [DW-1:0]  w_im,
  input  logic                  conj,
  output logic signed [2*DW+1:0] rr,
  output logic signed [2*DW+1:0] ii,
  output logic signed [2*DW+1:0] ri,
  output logic signed [2*DW+1:0] ir
);

  localparam int PW = 2 * DW + 2;

  logic signed [DW:0] x_re_q, x_im_q, w_re_q, w_im_q;
  logic signed [DW:0] w_re_x, w_im_x, w_im_c;

  // One extra bit so that negating the most negative twiddle is exact.
  always_comb begin
    w_re_x = {w_re[DW-1], w_re};
    w_im_x = {w_im[DW-1], w_im};
    w_im_c = conj ? -w_im_x : w_im_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_re_q <= '0;
      x_im_q <= '0;
      w_re_q <= '0;
      w_im_q <= '0;
      rr     <= '0;
      ii     <= '0;
      ri     <= '0;
      ir     <= '0;
    end else if (ce) begin
      x_re_q <= x_re;
      x_im_q <= x_im;
      w_re_q <= w_re_x;
      w_im_q <= w_im_c;
      rr     <= PW'(x_re_q) * PW'(w_re_q);
      ii     <= PW'(x_im_q) * PW'(w_im_q);
      ri     <= PW'(x_re_q) * PW'(w_im_q);
      ir     <= PW'(x_im_q) * PW'(w_re_q);
    end
  end

endmodule

// File: rtl/bf_radix2_pipe.sv
// Radix-2 DIF butterfly, 3-cycle pipeline: Y0 = A+B, Y1 = (A-B)*W with
// round-half-up, optional /2 scaling, saturation and conjugate-twiddle mode.
module bf_radix2_pipe
  import fft_pkg::*;
#(
  parameter int DW     = FFT_DW,
  parameter int FRAC   = FFT_FRAC,
  parameter int OVF_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic                 scale_en,
  input  logic                 inverse,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [DW-1:0] w_re,
  input  logic signed [DW-1:0] w_im,
  output logic                 out_valid,
  output logic signed [DW-1:0] y0_re,
  output logic signed [DW-1:0] y0_im,
  output logic signed [DW-1:0] y1_re,
  output logic signed [DW-1:0] y1_im,
  output logic                 ovf_sticky,
  input  logic                 ovf_clr
);

  localparam int PW = 2 * DW + 2;

  // Handshake: a sample is accepted on a rising edge with ce=1 and in_valid=1;
  // out_valid marks y* valid and, like all stages, only advances when ce=1.
  logic signed [DW:0]   sum_re_c, sum_im_c, diff_re_c, diff_im_c;
  logic signed [DW:0]   sum_re1, sum_im1, sum_re2, sum_im2;
  logic                 v1, v2, sc1, sc2;
  logic signed [PW-1:0] rr, ii, ri, ir;
  logic signed [PW:0]   p_re, p_im;
  rs_t                  y0r, y0i, y1r, y1i;
  logic                 ovf_any;

  always_comb begin
    sum_re_c  = {a_re[DW-1], a_re} + {b_re[DW-1], b_re};
    sum_im_c  = {a_im[DW-1], a_im} + {b_im[DW-1], b_im};
    diff_re_c = {a_re[DW-1], a_re} - {b_re[DW-1], b_re};
    diff_im_c = {a_im[DW-1], a_im} - {b_im[DW-1], b_im};
  end

  cmult_pipe #(.DW(DW)) u_cmult (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .x_re  (diff_re_c),
    .x_im  (diff_im_c),
    .w_re  (w_re),
    .w_im  (w_im),
    .conj  (inverse),
    .rr    (rr),
    .ii    (ii),
    .ri    (ri),
    .ir    (ir)
  );

  always_comb begin
    p_re    = {rr[PW-1], rr} - {ii[PW-1], ii};
    p_im    = {ri[PW-1], ri} + {ir[PW-1], ir};
    y1r     = rnd_sat(RS_W'(p_re), FRAC + int'(sc2), DW, OVF_EN != 0);
    y1i     = rnd_sat(RS_W'(p_im), FRAC + int'(sc2), DW, OVF_EN != 0);
    y0r     = rnd_sat(RS_W'(sum_re2), int'(sc2), DW, OVF_EN != 0);
    y0i     = rnd_sat(RS_W'(sum_im2), int'(sc2), DW, OVF_EN != 0);
    ovf_any = y0r.ovf | y0i.ovf | y1r.ovf | y1i.ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_re1   <= '0;
      sum_im1   <= '0;
      sum_re2   <= '0;
      sum_im2   <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      sc1       <= 1'b0;
      sc2       <= 1'b0;
      out_valid <= 1'b0;
      y0_re     <= '0;
      y0_im     <= '0;
      y1_re     <= '0;
      y1_im     <= '0;
    end else if (ce) begin
      sum_re1   <= sum_re_c;
      sum_im1   <= sum_im_c;
      sum_re2   <= sum_re1;
      sum_im2   <= sum_im1;
      v1        <= in_valid;
      v2        <= v1;
      sc1       <= scale_en;
      sc2       <= sc1;
      out_valid <= v2;
      if (v2) begin
        y0_re <= DW'(y0r.val);
        y0_im <= DW'(y0i.val);
        y1_re <= DW'(y1r.val);
        y1_im <= DW'(y1i.val);
      end
    end
  end

  // Clear is independent of ce and beats a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ovf_sticky <= 1'b0;
    else if (ovf_clr)                ovf_sticky <= 1'b0;
    else if (ce && v2 && ovf_any)    ovf_sticky <= 1'b1;
  end

endmodule
